ap_mult_pipe: RTL and testbench

AP_MULT_PIPE -- requirements
Module: ap_mult_pipe

---
 rtl/ap_mult_pipe.sv | 173 +++++++++++++++++
 tb/tb_ap_mult_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_mult_pipe.sv
// Signed WIDTH x WIDTH Baugh-Wooley multiplier in a 3-stage valid/ready pipeline.
// Low product columns can be OR-approximated per transaction; inexact deliveries are counted.
module ap_mult_pipe #(
   parameter int WIDTH    = 8,
   parameter int APX_COLS = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] res,
   output logic               res_inexact,
   output logic [15:0]        inexact_cnt
);
   localparam int PW = 2 * WIDTH;

   // Handshake: a transfer occurs on any rising edge where valid & ready are both 1;
   // the producer holds its data until then. One global stall freezes every stage.
   logic stall;
   logic adv;

   logic                        s1_valid_q, s1_valid_d;
   logic                        s1_mode_q, s1_mode_d;
   logic [WIDTH-1:0][WIDTH-1:0] s1_pp_q, s1_pp_d;

   logic          s2_valid_q, s2_valid_d;
   logic [PW-1:0] s2_sum_q, s2_sum_d;
   logic [PW-1:0] s2_car_q, s2_car_d;
   logic          s2_inexact_q, s2_inexact_d;

   logic          out_valid_q, out_valid_d;
   logic [PW-1:0] res_q, res_d;
   logic          res_inexact_q, res_inexact_d;
   logic [15:0]   cnt_q, cnt_d;

   logic [PW-1:0] col_mask;
   logic [PW-1:0] col_seen;
   logic [PW-1:0] col_many;
   logic [PW-1:0] row;
   logic [PW-1:0] csa_sum;
   logic [PW-1:0] csa_car;
   logic [PW-1:0] csa_tmp;

   assign stall       = out_valid_q & ~out_ready;
   assign adv         = ~stall;
   assign in_ready    = adv;
   assign out_valid   = out_valid_q;
   assign res         = res_q;
   assign res_inexact = res_inexact_q;
   assign inexact_cnt = cnt_q;

   // S1: partial products, sign terms inverted where exactly one index is the MSB
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_mode_d  = s1_mode_q;
      s1_pp_d    = s1_pp_q;
      if (adv) begin
         s1_valid_d = in_valid;
         s1_mode_d  = mode;
         for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
               s1_pp_d[i][j] = (a[j] & b[i]) ^ ((i == WIDTH - 1) != (j == WIDTH - 1));
            end
         end
      end
      if (flush) begin
         s1_valid_d = 1'b0;
      end
   end

   // S2: approximated columns reduce to OR (no carry); the rest go through a 3:2 chain
   always_comb begin
      col_mask = '1;
      col_seen = '0;
      col_many = '0;
      if (s1_mode_q) begin
         for (int c = 0; c < APX_COLS; c++) begin
            col_mask[c] = 1'b0;
         end
      end
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            if (i + j < APX_COLS) begin
               col_many[i+j] = col_many[i+j] | (col_seen[i+j] & s1_pp_q[i][j]);
               col_seen[i+j] = col_seen[i+j] | s1_pp_q[i][j];
            end
         end
      end

      csa_sum         = '0;
      csa_sum[WIDTH]  = 1'b1;
      csa_sum[PW-1]   = 1'b1;
      csa_car         = '0;
      row             = '0;
      csa_tmp         = '0;
      for (int i = 0; i < WIDTH; i++) begin
         row     = (PW'(s1_pp_q[i]) << i) & col_mask;
         csa_tmp = csa_sum ^ csa_car ^ row;
         csa_car = ((csa_sum & csa_car) | (csa_sum & row) | (csa_car & row)) << 1;
         csa_sum = csa_tmp;
      end

      s2_valid_d   = s2_valid_q;
      s2_sum_d     = s2_sum_q;
      s2_car_d     = s2_car_q;
      s2_inexact_d = s2_inexact_q;
      if (adv) begin
         s2_valid_d   = s1_valid_q;
         // masked columns are zero in both rows, so the OR bits can be merged in directly
         s2_sum_d     = csa_sum | (s1_mode_q ? col_seen : '0);
         s2_car_d     = csa_car;
         s2_inexact_d = s1_mode_q & (|col_many);
      end
      if (flush) begin
         s2_valid_d = 1'b0;
      end
   end

   // S3: carry-propagate add into the output register, plus the saturating counter
   always_comb begin
      out_valid_d   = out_valid_q;
      res_d         = res_q;
      res_inexact_d = res_inexact_q;
      if (adv) begin
         out_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            res_d         = s2_sum_q + s2_car_q;
            res_inexact_d = s2_inexact_q;
         end
      end
      if (flush) begin
         out_valid_d = 1'b0;
      end

      cnt_d = cnt_q;
      if (out_valid_q && out_ready && res_inexact_q && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q    <= 1'b0;
         s2_valid_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         res_q         <= '0;
         res_inexact_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s2_valid_q    <= s2_valid_d;
         out_valid_q   <= out_valid_d;
         res_q         <= res_d;
         res_inexact_q <= res_inexact_d;
         cnt_q         <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      s1_mode_q    <= s1_mode_d;
      s1_pp_q      <= s1_pp_d;
      s2_sum_q     <= s2_sum_d;
      s2_car_q     <= s2_car_d;
      s2_inexact_q <= s2_inexact_d;
   end

endmodule

// File: tb/tb_ap_mult_pipe.sv
// Randomised and directed bench for ap_mult_pipe against an arithmetic model
// of exact and column-approximated signed products.
module tb_ap_mult_pipe;
   localparam int W  = 8;
   localparam int AC = 5;

   logic           clk;
   logic           rst_n;
   logic           flush;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           mode;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] res;
   logic           res_inexact;
   logic [15:0]    inexact_cnt;

   logic or_main;
   logic rnd_ready;
   logic rand_en;
   assign out_ready = rand_en ? rnd_ready : or_main;

   int n_chk  = 0;
   int n_fail = 0;
   int n_deliv = 0;
   logic [2*W:0] exp_q[$];
   logic [15:0]  exp_cnt;
   logic         prev_stall;
   logic [2*W-1:0] prev_res;
   logic         prev_inx;

   ap_mult_pipe #(.WIDTH(W), .APX_COLS(AC)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .res_inexact(res_inexact), .inexact_cnt(inexact_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
   end

   // exact product minus the per-column bit counts plus per-column ORs
   function automatic logic [2*W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic m);
      logic [2*W-1:0] xs, ys, p, l, o;
      int cnt;
      xs = {{W{x[W-1]}}, x};
      ys = {{W{y[W-1]}}, y};
      p  = xs * ys;
      l  = '0;
      o  = '0;
      if (m) begin
         for (int c = 0; c < AC; c++) begin
            cnt = 0;
            for (int i = 0; i < W; i++) begin
               for (int j = 0; j < W; j++) begin
                  if (i + j == c) cnt += int'(x[j] & y[i]);
               end
            end
            l = l + ((2*W)'(cnt) << c);
            o = o + ((2*W)'(cnt != 0) << c);
         end
      end
      return {(l != o), p - l + o};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // scoreboard / compare process
   always @(negedge clk) begin
      logic [2*W:0] e;
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_res", res, 0);
         chk("rst_res_inexact", res_inexact, 0);
         chk("rst_cnt", inexact_cnt, 0);
         chk("rst_in_ready", in_ready, 1);
         exp_q.delete();
         exp_cnt    = '0;
         prev_stall = 1'b0;
      end else begin
         chk("in_ready", in_ready, !(out_valid && !out_ready));
         chk("inexact_cnt", inexact_cnt, exp_cnt);
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_res", res, prev_res);
            chk("stall_inx", res_inexact, prev_inx);
         end
         if (out_valid && exp_q.size() == 0) begin
            chk("spurious_out_valid", out_valid, 0);
         end else if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            chk("res", res, e[2*W-1:0]);
            chk("res_inexact", res_inexact, e[2*W]);
            n_deliv++;
            if (e[2*W] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         end
         if (flush) exp_q.delete();
         if (in_valid && in_ready && !flush) exp_q.push_back(model(a, b, mode));
         prev_stall = out_valid && !out_ready && !flush;
         prev_res   = res;
         prev_inx   = res_inexact;
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xm);
      logic got;
      int budget;
      a = xa; b = xb; mode = xm; in_valid = 1'b1;
      got = 1'b0;
      budget = 200;
      while (!got && budget > 0) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         budget--;
      end
      in_valid = 1'b0;
      if (!got) chk("send_accept_timeout", got, 1);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || out_valid) && k < 300) begin
         tick(1);
         k++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic wait_out();
      int k;
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("wait_out_valid", out_valid, 1);
   endtask

   initial begin
      logic [15:0] cnt0;
      int d0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0;
      or_main = 1'b1; rand_en = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);

      // literal pins on the model itself
      chk("model_m128sq", model(8'h80, 8'h80, 1'b0), {1'b0, 16'h4000});
      chk("model_1f_apx", model(8'h1F, 8'h1F, 1'b1), {1'b1, 16'h035F});
      chk("model_03_apx", model(8'h03, 8'h03, 1'b1), {1'b1, 16'h0007});
      chk("model_ff_apx", model(8'hFF, 8'hFF, 1'b1), {1'b1, 16'hFF9F});
      chk("model_1f_exact", model(8'h1F, 8'h1F, 1'b0), {1'b0, 16'h03C1});

      // latency: out_valid exactly 3 cycles after accept
      send(8'h80, 8'h80, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("latency_valid", out_valid, (k == 3));
         if (k == 3) begin
            chk("m128sq_res", res, 16'h4000);
            chk("m128sq_inx", res_inexact, 0);
         end
         @(posedge clk);
         #1;
      end
      drain();

      // approximate result and counter increment on handshake
      cnt0 = inexact_cnt;
      send(8'h1F, 8'h1F, 1'b1);
      wait_out();
      chk("apx1f_res", res, 16'h035F);
      chk("apx1f_inx", res_inexact, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("apx1f_cnt", inexact_cnt, cnt0 + 16'd1);
      tick(1);
      drain();

      // back-to-back stream against a stalled output
      d0 = n_deliv;
      or_main = 1'b0;
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               send(W'($urandom), W'($urandom), 1'($urandom));
            end
         end
         begin
            tick(8);
            or_main = 1'b1;
         end
      join
      drain();
      chk("stall_delivered", n_deliv - d0, 5);

      // flush with three in flight while stalled
      or_main = 1'b0;
      cnt0 = inexact_cnt;
      send(8'h1F, 8'h1F, 1'b1);
      send(8'h33, 8'h7F, 1'b1);
      send(8'hFF, 8'hFF, 1'b1);
      do_flush();
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      chk("flush_cnt", inexact_cnt, cnt0);
      @(posedge clk);
      #1;
      or_main = 1'b1;
      tick(10);
      drain();

      // randomised traffic with flushes and a mid-stream reset
      rand_en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
         if ($urandom_range(0, 99) == 0) do_flush();
         if (i == 700) do_reset();
         send(W'($urandom), W'($urandom), 1'($urandom));
      end
      rand_en = 1'b0;
      or_main = 1'b1;
      drain();

      // counter saturation
      do_reset();
      for (int i = 0; i < 65534; i++) send(8'h1F, 8'h1F, 1'b1);
      drain();
      @(negedge clk);
      chk("cnt_fffe", inexact_cnt, 16'hFFFE);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) send(8'h1F, 8'h1F, 1'b1);
      drain();
      @(negedge clk);
      chk("cnt_ffff", inexact_cnt, 16'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
